// File: rtl/lvds_frame_gate_pkg.sv
// Shared definitions for the LVDS frame gate: FSM encoding and the {group, data}
// FIFO word layout that the AXI-Stream stage also decodes.
package lvds_frame_gate_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_WRITE    = 2'd2,
    ST_DROP     = 2'd3
  } state_t;

  // Data occupies the low DW bits; the group flag sits directly above it.
  localparam int WORD_DATA_LSB = 0;

  function automatic int word_group_bit(input int dw);
    return WORD_DATA_LSB + dw;
  endfunction

endpackage

// File: rtl/lvds_frame_gate_sync_2ff.sv
// Generic single-bit two-flop synchronizer with asynchronous active-low reset,
// used for slow PS-side control levels entering the CLK_IN domain.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/lvds_frame_gate.sv
// Frame-aligned write gate: admits only whole FRAME_NUM-word frames into the
// receive FIFO, dropping a frame entirely when the FIFO cannot hold it.
module lvds_frame_gate
  import lvds_frame_gate_pkg::*;
#(
  parameter int DW         = 15,
  parameter int FRAME_NUM  = 1024,
  parameter int FIFO_DEPTH = 4096,
  parameter int MARGIN     = 8,
  parameter int CW         = 16
) (
  input  logic                            CLK_IN,
  input  logic                            rst_n,
  input  logic                            en_async,
  input  logic [DW-1:0]                   data_in,
  input  logic                            group_in,
  input  logic [$clog2(FIFO_DEPTH):0]     fifo_wr_count,
  input  logic                            fifo_full,
  output logic                            fifo_wr_en,
  output logic [DW:0]                     fifo_wr_data,
  output logic                            busy,
  output logic [CW-1:0]                   frame_cnt,
  output logic [CW-1:0]                   drop_cnt,
  output logic                            err_ovf,
  output logic [1:0]                      o_state
);

  localparam int CNTW    = $clog2(FIFO_DEPTH) + 1;
  localparam int WCW     = $clog2(FRAME_NUM);
  localparam int GRP_BIT = word_group_bit(DW);
  localparam logic [CNTW-1:0] DEPTH_C = CNTW'(FIFO_DEPTH);
  localparam logic [CNTW-1:0] NEED_C  = CNTW'(FRAME_NUM + MARGIN);
  localparam logic [WCW-1:0]  LAST_C  = WCW'(FRAME_NUM - 1);

  logic [DW-1:0]   r_data;
  logic            r_group;
  logic            r_group_rr;
  logic            w_en_s;
  logic            w_sof;
  logic [CNTW-1:0] w_free;
  logic            w_has_room;
  logic            w_last;

  state_t          r_state, w_state_nxt;
  logic [WCW-1:0]  r_word_cnt, w_word_cnt_nxt;
  logic            r_wr_en, w_wr_en_nxt;
  logic [DW:0]     r_wr_data;
  logic [CW-1:0]   r_frame_cnt, w_frame_cnt_nxt;
  logic [CW-1:0]   r_drop_cnt, w_drop_cnt_nxt;
  logic            r_err_ovf, w_err_ovf_nxt;

  sync_2ff u_en_sync (
    .clk   (CLK_IN),
    .rst_n (rst_n),
    .d     (en_async),
    .q     (w_en_s)
  );

  assign w_sof      = r_group & ~r_group_rr;
  assign w_free     = DEPTH_C - fifo_wr_count;
  assign w_has_room = (w_free >= NEED_C);
  assign w_last     = (r_word_cnt == LAST_C);

  always_comb begin
    w_state_nxt     = r_state;
    w_word_cnt_nxt  = r_word_cnt;
    w_wr_en_nxt     = 1'b0;
    w_frame_cnt_nxt = r_frame_cnt;
    w_drop_cnt_nxt  = r_drop_cnt;
    w_err_ovf_nxt   = r_err_ovf;
    case (r_state)
      ST_IDLE: begin
        if (w_en_s) w_state_nxt = ST_WAIT_SOF;
      end
      ST_WAIT_SOF: begin
        if (!w_en_s) begin
          w_state_nxt = ST_IDLE;
        end else if (w_sof) begin
          w_word_cnt_nxt = WCW'(1);
          if (w_has_room) begin
            w_state_nxt = ST_WRITE;
            if (fifo_full) w_err_ovf_nxt = 1'b1;
            else           w_wr_en_nxt   = 1'b1;
          end else begin
            w_state_nxt    = ST_DROP;
            w_drop_cnt_nxt = r_drop_cnt + CW'(1);
          end
        end
      end
      ST_WRITE: begin
        // A full FIFO loses the word but the count keeps frame alignment.
        if (fifo_full) w_err_ovf_nxt = 1'b1;
        else           w_wr_en_nxt   = 1'b1;
        if (w_last) begin
          w_word_cnt_nxt  = '0;
          w_frame_cnt_nxt = r_frame_cnt + CW'(1);
          w_state_nxt     = w_en_s ? ST_WAIT_SOF : ST_IDLE;
        end else begin
          w_word_cnt_nxt = r_word_cnt + WCW'(1);
        end
      end
      ST_DROP: begin
        if (w_last) begin
          w_word_cnt_nxt = '0;
          w_state_nxt    = w_en_s ? ST_WAIT_SOF : ST_IDLE;
        end else begin
          w_word_cnt_nxt = r_word_cnt + WCW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_IN or negedge rst_n) begin
    if (!rst_n) begin
      r_data      <= '0;
      r_group     <= 1'b0;
      r_group_rr  <= 1'b0;
      r_state     <= ST_IDLE;
      r_word_cnt  <= '0;
      r_wr_en     <= 1'b0;
      r_wr_data   <= '0;
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
      r_err_ovf   <= 1'b0;
    end else begin
      r_data      <= data_in;
      r_group     <= group_in;
      r_group_rr  <= r_group;
      r_state     <= w_state_nxt;
      r_word_cnt  <= w_word_cnt_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_wr_data[GRP_BIT]               <= r_group;
      r_wr_data[WORD_DATA_LSB +: DW]   <= r_data;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_drop_cnt  <= w_drop_cnt_nxt;
      r_err_ovf   <= w_err_ovf_nxt;
    end
  end

  // fifo_wr_en is a single-cycle strobe qualifying fifo_wr_data; the FIFO has no
  // ready path, so room is checked once per frame and fifo_full per word.
  assign fifo_wr_en   = r_wr_en;
  assign fifo_wr_data = r_wr_data;
  assign busy         = (r_state == ST_WRITE) || (r_state == ST_DROP);
  assign frame_cnt    = r_frame_cnt;
  assign drop_cnt     = r_drop_cnt;
  assign err_ovf      = r_err_ovf;
  assign o_state      = r_state;

endmodule

// File: tb/tb_lvds_frame_gate.sv
// Self-checking bench for lvds_frame_gate with a frame-level reference model.
module tb_lvds_frame_gate;

  localparam int FRAME_NUM  = 1024;
  localparam int FIFO_DEPTH = 4096;
  localparam int MARGIN     = 8;

  logic        CLK_IN;
  logic        rst_n;
  logic        en_async;
  logic [14:0] data_in;
  logic        group_in;
  logic [12:0] fifo_wr_count;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [15:0] fifo_wr_data;
  logic        busy;
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;
  logic        err_ovf;
  logic [1:0]  o_state;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int run_len = 0;
  int max_run = 0;
  int m_frames = 0;
  int m_drops = 0;
  logic m_err = 1'b0;

  lvds_frame_gate dut (
    .CLK_IN        (CLK_IN),
    .rst_n         (rst_n),
    .en_async      (en_async),
    .data_in       (data_in),
    .group_in      (group_in),
    .fifo_wr_count (fifo_wr_count),
    .fifo_full     (fifo_full),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_wr_data  (fifo_wr_data),
    .busy          (busy),
    .frame_cnt     (frame_cnt),
    .drop_cnt      (drop_cnt),
    .err_ovf       (err_ovf),
    .o_state       (o_state)
  );

  // clock
  initial CLK_IN = 1'b0;
  always #2 CLK_IN = ~CLK_IN;

  // collect FIFO writes and the longest run of consecutive write cycles
  always @(negedge CLK_IN) begin
    if (fifo_wr_en === 1'b1) begin
      got_q.push_back(fifo_wr_data);
      run_len = run_len + 1;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
  end

  task automatic drive(input logic g, input logic [14:0] d, input logic [12:0] c, input logic f);
    @(negedge CLK_IN);
    group_in      = g;
    data_in       = d;
    fifo_wr_count = c;
    fifo_full     = f;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 15'($urandom), 13'd0, 1'b0);
  endtask

  // Drive one frame; the model decides from the rules: enabled at SOF and
  // free = depth - count >= FRAME_NUM + MARGIN means written, else dropped.
  task automatic send_frame(input int gap, input logic [12:0] cnt, input int full_at,
                            input int sof2_at, input int en_off_at, input int stop_at,
                            input bit idx_data);
    bit en_ok;
    bit room;
    logic [14:0] d;
    logic g;
    idle(gap);
    en_ok = (en_async === 1'b1);
    room  = ((FIFO_DEPTH - int'(cnt)) >= FRAME_NUM + MARGIN);
    for (int i = 0; i < FRAME_NUM; i++) begin
      if (i == stop_at) return;
      d = idx_data ? 15'(i) : 15'($urandom);
      g = (i == 0) || (i == sof2_at);
      if (i == en_off_at) en_async = 1'b0;
      drive(g, d, (i == 1) ? cnt : 13'd0, (full_at >= 0) && (i == full_at + 1));
      if (en_ok && room && i != full_at) exp_q.push_back({g, d});
    end
    if (en_ok && room) begin
      m_frames++;
      if (full_at >= 0) m_err = 1'b1;
    end else if (en_ok) begin
      m_drops++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en_async = 1'b0; data_in = '0; group_in = 1'b0;
    fifo_wr_count = '0; fifo_full = 1'b0;
    repeat (3) @(negedge CLK_IN);
    checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", fifo_wr_en); end
    checks++; if (fifo_wr_data !== 16'h0) begin errors++; $display("FAIL reset_wr_data: got %h want 0000", fifo_wr_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (frame_cnt !== 16'd0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_counters: got %0d/%0d want 0/0", frame_cnt, drop_cnt); end
    checks++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_ovf); end
    checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", o_state); end
    rst_n = 1'b1;
    idle(4);
    checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL idle_no_en: got state %0d want 0", o_state); end
  endtask

  task automatic test_basic;
    int nbad;
    en_async = 1'b1;
    send_frame(8, 13'd0, -1, -1, -1, -1, 1'b1);
    drive(1'b0, 15'd0, 13'd0, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_hold: got %b want 1", busy); end
    drive(1'b0, 15'd0, 13'd0, 1'b0);
    checks++; if (busy !== 1'b0 || fifo_wr_en !== 1'b1 || fifo_wr_data !== 16'h03FF) begin
      errors++; $display("FAIL basic_last_word: got busy=%b en=%b data=%h want 0 1 03ff", busy, fifo_wr_en, fifo_wr_data); end
    idle(4);
    checks++; if (got_q.size() !== 1024) begin errors++; $display("FAIL basic_count: got %0d want 1024", got_q.size()); end
    checks++; if (got_q.size() == 0 || got_q[0] !== 16'h8000) begin errors++; $display("FAIL basic_first: got %h want 8000", (got_q.size() > 0) ? got_q[0] : 16'hxxxx); end
    nbad = 0;
    for (int i = 0; i < exp_q.size(); i++) if (i >= got_q.size() || got_q[i] !== exp_q[i]) nbad++;
    checks++; if (nbad != 0) begin errors++; $display("FAIL basic_data: got %0d bad words want 0", nbad); end
    checks++; if (frame_cnt !== 16'(m_frames)) begin errors++; $display("FAIL basic_frame_cnt: got %0d want %0d", frame_cnt, m_frames); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back;
    int nbad;
    max_run = 0;
    send_frame(4, 13'd0, -1, -1, -1, -1, 1'b0);
    send_frame(0, 13'd0, -1, -1, -1, -1, 1'b0);
    send_frame(0, 13'd0, -1, -1, -1, -1, 1'b0);
    idle(6);
    checks++; if (got_q.size() !== 3072) begin errors++; $display("FAIL b2b_count: got %0d want 3072", got_q.size()); end
    checks++; if (max_run !== 3072) begin errors++; $display("FAIL b2b_contiguous: got run %0d want 3072", max_run); end
    nbad = 0;
    for (int i = 0; i < exp_q.size(); i++) if (i >= got_q.size() || got_q[i] !== exp_q[i]) nbad++;
    checks++; if (nbad != 0) begin errors++; $display("FAIL b2b_data: got %0d bad words want 0", nbad); end
    checks++; if (frame_cnt !== 16'(m_frames) || drop_cnt !== 16'(m_drops)) begin
      errors++; $display("FAIL b2b_counters: got %0d/%0d want %0d/%0d", frame_cnt, drop_cnt, m_frames, m_drops); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_no_space;
    int nbad;
    logic [12:0] c;
    send_frame(3, 13'd3100, -1, -1, -1, -1, 1'b0);
    idle(2);
    checks++; if (drop_cnt !== 16'(m_drops) || got_q.size() !== 0) begin
      errors++; $display("FAIL nospace_drop: got drops=%0d writes=%0d want %0d/0", drop_cnt, got_q.size(), m_drops); end
    send_frame(0, 13'd0, -1, -1, -1, -1, 1'b0);
    send_frame(2, 13'd3064, -1, -1, -1, -1, 1'b0);
    send_frame(0, 13'd3065, -1, -1, -1, -1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      c = ($urandom_range(0, 1) == 1) ? 13'($urandom_range(0, 3064)) : 13'($urandom_range(3065, 4095));
      send_frame($urandom_range(0, 5), c, -1, -1, -1, -1, 1'b0);
    end
    idle(6);
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL nospace_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    nbad = 0;
    for (int i = 0; i < exp_q.size(); i++) if (i >= got_q.size() || got_q[i] !== exp_q[i]) nbad++;
    checks++; if (nbad != 0) begin errors++; $display("FAIL nospace_data: got %0d bad words want 0", nbad); end
    checks++; if (frame_cnt !== 16'(m_frames) || drop_cnt !== 16'(m_drops)) begin
      errors++; $display("FAIL nospace_counters: got %0d/%0d want %0d/%0d", frame_cnt, drop_cnt, m_frames, m_drops); end
    checks++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL nospace_err: got %b want 0", err_ovf); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_spurious_full;
    int nbad;
    send_frame(4, 13'd0, 700, 500, -1, -1, 1'b0);
    idle(4);
    checks++; if (got_q.size() !== 1023) begin errors++; $display("FAIL spur_count: got %0d want 1023", got_q.size()); end
    checks++; if (err_ovf !== 1'b1) begin errors++; $display("FAIL spur_err_set: got %b want 1", err_ovf); end
    checks++; if (busy !== 1'b0 || o_state !== 2'd1) begin errors++; $display("FAIL spur_end: got busy=%b state=%0d want 0/1", busy, o_state); end
    send_frame(0, 13'd0, -1, -1, -1, -1, 1'b0);
    idle(4);
    nbad = 0;
    for (int i = 0; i < exp_q.size(); i++) if (i >= got_q.size() || got_q[i] !== exp_q[i]) nbad++;
    checks++; if (nbad != 0 || got_q.size() !== exp_q.size()) begin errors++; $display("FAIL spur_data: got %0d bad of %0d want 0 of %0d", nbad, got_q.size(), exp_q.size()); end
    checks++; if (err_ovf !== m_err) begin errors++; $display("FAIL spur_err_sticky: got %b want %b", err_ovf, m_err); end
    checks++; if (frame_cnt !== 16'(m_frames)) begin errors++; $display("FAIL spur_frame_cnt: got %0d want %0d", frame_cnt, m_frames); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_en_drop;
    send_frame(4, 13'd0, -1, -1, 300, -1, 1'b0);
    idle(4);
    checks++; if (got_q.size() !== 1024) begin errors++; $display("FAIL endrop_complete: got %0d want 1024", got_q.size()); end
    checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL endrop_idle: got state %0d want 0", o_state); end
    send_frame(6, 13'd0, -1, -1, -1, -1, 1'b0);
    idle(4);
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL endrop_no_write: got %0d want %0d", got_q.size(), exp_q.size()); end
    checks++; if (drop_cnt !== 16'(m_drops) || frame_cnt !== 16'(m_frames)) begin
      errors++; $display("FAIL endrop_counters: got %0d/%0d want %0d/%0d", frame_cnt, drop_cnt, m_frames, m_drops); end
    got_q.delete(); exp_q.delete();
    en_async = 1'b1;
  endtask

  task automatic test_reset_mid;
    int nbad;
    send_frame(8, 13'd0, -1, -1, -1, 400, 1'b0);
    checks++; if (fifo_wr_en !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got en=%b busy=%b want 1/1", fifo_wr_en, busy); end
    #1 rst_n = 1'b0;
    #0.5;
    checks++; if (fifo_wr_en !== 1'b0 || fifo_wr_data !== 16'h0 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_outputs: got en=%b data=%h busy=%b want 0/0000/0", fifo_wr_en, fifo_wr_data, busy); end
    checks++; if (frame_cnt !== 16'd0 || drop_cnt !== 16'd0 || err_ovf !== 1'b0 || o_state !== 2'd0) begin
      errors++; $display("FAIL rstmid_state: got f=%0d d=%0d err=%b st=%0d want 0/0/0/0", frame_cnt, drop_cnt, err_ovf, o_state); end
    @(negedge CLK_IN);
    rst_n = 1'b1;
    got_q.delete(); exp_q.delete();
    m_frames = 0; m_drops = 0; m_err = 1'b0;
    send_frame(8, 13'($urandom_range(0, 2000)), -1, -1, -1, -1, 1'b0);
    idle(4);
    nbad = 0;
    for (int i = 0; i < exp_q.size(); i++) if (i >= got_q.size() || got_q[i] !== exp_q[i]) nbad++;
    checks++; if (nbad != 0 || got_q.size() !== 1024) begin errors++; $display("FAIL rstmid_recover: got %0d bad, %0d writes want 0/1024", nbad, got_q.size()); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL rstmid_frame_cnt: got %0d want 1", frame_cnt); end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_no_space;
    test_spurious_full;
    test_en_drop;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
